// File: rtl/xperm_arb_rv32_pkg.sv
// Shared crypto-FU definitions: permutation op encodings and the arbiter state type.
package xperm_arb_rv32_pkg;

  typedef enum logic {
    OP_XPERM8 = 1'b0,
    OP_XPERM4 = 1'b1
  } xperm_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  localparam int XLEN = 32;

endpackage

// File: rtl/xperm_core_rv32.sv
// Combinational xperm8/xperm4 lookup; an index past the source's element count yields zero.
module xperm_core_rv32
  import xperm_arb_rv32_pkg::*;
(
  input  logic        op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] rd_o
);

  logic [31:0] rd8;
  logic [31:0] rd4;

  always_comb begin
    logic [7:0] k8;
    rd8 = '0;
    k8  = '0;
    for (int i = 0; i < 4; i++) begin
      k8 = rs1_i[i*8 +: 8];
      // Full-width compare: an index like 0x80 must not alias element 0.
      if (k8 < 8'd4) rd8[i*8 +: 8] = rs2_i[{k8[1:0], 3'b000} +: 8];
    end
  end

  always_comb begin
    logic [3:0] k4;
    rd4 = '0;
    k4  = '0;
    for (int i = 0; i < 8; i++) begin
      k4 = rs1_i[i*4 +: 4];
      if (k4 < 4'd8) rd4[i*4 +: 4] = rs2_i[{k4[2:0], 2'b00} +: 4];
    end
  end

  assign rd_o = (op_i == OP_XPERM4) ? rd4 : rd8;

endmodule

// File: rtl/xperm_arb_rv32.sv
// Two-requester round-robin front end for a shared xperm unit with a single
// output register (1-cycle latency, full throughput, back-pressure via rsp_ready_i).
module xperm_arb_rv32
  import xperm_arb_rv32_pkg::*;
#(
  parameter int unsigned RR_INIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req0_rs1_i,
  input  logic [31:0] req0_rs2_i,
  input  logic [31:0] req1_rs1_i,
  input  logic [31:0] req1_rs2_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rd_o,
  output logic        rsp_id_o,
  output logic        busy_o
);

  localparam logic PRIO_RST = (RR_INIT != 0);

  arb_state_e  state_q, state_d;
  logic        prio_q, prio_d;
  logic [31:0] rd_q, rd_d;
  logic        id_q, id_d;

  logic        accept;
  logic        any_valid;
  logic        gnt_id;
  logic        xfer;
  logic        drain;
  logic        sel_op;
  logic [31:0] sel_rs1;
  logic [31:0] sel_rs2;
  logic [31:0] core_rd;

  assign accept    = (state_q == ST_EMPTY) || rsp_ready_i;
  assign any_valid = |req_valid_i;
  assign gnt_id    = (&req_valid_i) ? prio_q : req_valid_i[1];

  // Ready is forced low during reset so nothing can be accepted into a register being cleared.
  assign req_ready_o[0] = !rst_i && accept && any_valid && (gnt_id == 1'b0);
  assign req_ready_o[1] = !rst_i && accept && any_valid && (gnt_id == 1'b1);

  assign xfer  = |(req_valid_i & req_ready_o);
  assign drain = (state_q == ST_FULL) && rsp_ready_i;

  assign sel_op  = gnt_id ? req_op_i[1] : req_op_i[0];
  assign sel_rs1 = gnt_id ? req1_rs1_i  : req0_rs1_i;
  assign sel_rs2 = gnt_id ? req1_rs2_i  : req0_rs2_i;

  xperm_core_rv32 u_core (
    .op_i  (sel_op),
    .rs1_i (sel_rs1),
    .rs2_i (sel_rs2),
    .rd_o  (core_rd)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      prio_q  <= PRIO_RST;
      rd_q    <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      rd_q    <= rd_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    rd_d    = rd_q;
    id_d    = id_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (drain && !xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (xfer) begin
      rd_d   = core_rd;
      id_d   = gnt_id;
      prio_d = ~gnt_id;
    end
  end

  assign rsp_valid_o = (state_q == ST_FULL);
  assign rsp_rd_o    = rd_q;
  assign rsp_id_o    = id_q;
  assign busy_o      = rsp_valid_o;

endmodule

// File: doc/xperm_arb_rv32.md
XPERM_ARB_RV32 -- requirements
Module: xperm_arb_rv32

Interface
REQ-001 The block SHALL have one parameter: RR_INIT, default 0, meaning the requester index that holds priority after reset.
REQ-002 The block SHALL have the port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_i, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have the ports req_valid_i[1:0], input, 2, per-requester request valid.
REQ-005 The block SHALL have the ports req_ready_o[1:0], output, 2, per-requester request accept.
REQ-006 The block SHALL have the ports req_op_i[1:0], input, 2, per-requester op: 0 = xperm8, 1 = xperm4.
REQ-007 The block SHALL have the ports req0_rs1_i, req0_rs2_i, req1_rs1_i and req1_rs2_i, input, 32 each, the operands.
REQ-008 The block SHALL have the ports rsp_valid_o, output, 1; rsp_ready_i, input, 1; rsp_rd_o, output, 32; rsp_id_o, output, 1 (the granted requester).
REQ-009 The block SHALL have the port busy_o, output, 1, high while the response register holds data.

Function
REQ-010 A request transfer SHALL occur in a cycle when req_valid_i[n] and req_ready_o[n] are both high; a response transfer SHALL occur in a cycle when rsp_valid_o and rsp_ready_i are both high.
REQ-011 The accept condition SHALL be accept = !rsp_valid_o || rsp_ready_i.
REQ-012 req_ready_o[n] SHALL be high only when accept is high and requester n is granted; at most one bit of req_ready_o SHALL be high in any cycle.
REQ-013 Grant SHALL go to the only valid requester; when both are valid it SHALL go to the requester holding priority (prio).
REQ-014 After each request transfer, prio SHALL become the non-granted index; prio SHALL be unchanged in cycles with no transfer.
REQ-015 The arbiter state SHALL be two states, EMPTY and FULL (register valid), with these transitions: EMPTY->FULL on a transfer; FULL->EMPTY on a drain with no new transfer; FULL->FULL on a drain plus a transfer in the same cycle (back-to-back); FULL->FULL holding all outputs stable while rsp_ready_i is low.
REQ-016 Latency SHALL be 1 cycle: a request accepted in cycle t SHALL appear on rsp_valid_o/rsp_rd_o/rsp_id_o in cycle t+1.
REQ-017 Sustained throughput SHALL be one operation per cycle while rsp_ready_i stays high.
REQ-018 xperm8 SHALL compute, for each i in 0..3, rd byte i = rs2 byte k, where k = rs1 byte i; the result byte SHALL be 0x00 when k >= 4, i.e. the full 8-bit index is compared, not only its low 2 bits.
REQ-019 xperm4 SHALL compute, for each i in 0..7, rd nibble i = rs2 nibble k, where k = rs1 nibble i; the result nibble SHALL be 0x0 when k >= 8.
REQ-020 Operand and op inputs SHALL be sampled only at transfer; changes to them in non-transfer cycles SHALL have no effect.
REQ-021 A requester whose valid is low SHALL never be granted, whatever its priority.
REQ-022 busy_o SHALL equal rsp_valid_o.

Reset
REQ-023 While rst_i is high at a clock edge, the block SHALL set rsp_valid_o=0, rsp_rd_o=0, rsp_id_o=0, busy_o=0 and prio=RR_INIT.
REQ-024 While rst_i is high, req_ready_o SHALL be 2'b00.
REQ-025 Reset asserted while the block is FULL SHALL discard the held response without a transfer.
REQ-026 The first grant after reset release SHALL follow REQ-013 using prio=RR_INIT.

Structure
REQ-027 The op encodings (OP_XPERM8, OP_XPERM4) SHALL live in the shared crypto-FU package.
REQ-028 The permutation datapath SHALL be a single combinational sub-module, xperm_core_rv32 (inputs op, rs1, rs2; output rd), instantiated once and fed by a 2:1 operand mux driven by the grant.

Verification
REQ-029 Bench SHALL cover: xperm8 with rs1=0x00010203, rs2=0x44332211 -> rsp_rd_o=0x11223344 one cycle later.
REQ-030 Bench SHALL cover: xperm8 with rs1=0x04000100, rs2=0x44332211 -> 0x00112211 (out-of-range index zeroed).
REQ-031 Bench SHALL cover: xperm4 with rs1=0x01234567, rs2=0x76543210 -> 0x01234567; and xperm4 with rs1=0x00000008 -> nibble0=0.
REQ-032 Bench SHALL cover: both requesters valid for 4 cycles with rsp_ready_i=1 and RR_INIT=0 -> rsp_id_o sequence 0,1,0,1 with no bubbles.
REQ-033 Bench SHALL cover: rsp_ready_i held low for 3 cycles while FULL -> req_ready_o=00 and all rsp outputs stable; then rsp_ready_i=1 -> drain plus a new accept in the same cycle.
REQ-034 Bench SHALL cover: rst_i asserted while FULL -> next cycle rsp_valid_o=0 and req_ready_o=00; after release the first grant goes to RR_INIT when both requesters are valid.
